// File: rtl/approx_mult_pipe.sv
// ---------------------------------------------------------------------------
// approx_mult_pipe
//
// Three-stage pipelined WIDTH x WIDTH unsigned multiplier. The precision is
// chosen per transaction: in approximate mode, columns 0..APPROX_COLS-1 of
// the partial-product matrix are OR-compressed and produce no carry. All
// higher columns are always reduced exactly.
//
//   S1 : operand and mode registers
//   S2 : partial-product generation and carry-save reduction to two rows
//   S3 : final carry-propagate add into the output register
//
// Handshake: en = !out_valid | out_ready. Every stage advances only when en
// is high, and in_ready = en. While rst_n is low, in_ready is forced high.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand transfer request
//   in_ready   out  operands are accepted this cycle
//   in_a       in   WIDTH-bit multiplicand, unsigned
//   in_b       in   WIDTH-bit multiplier, unsigned
//   in_approx  in   1 = approximate, 0 = exact
//   out_valid  out  result available
//   out_ready  in   downstream accepts the result
//   out_p      out  2*WIDTH-bit product
//   out_approx out  mode the result was computed in
//
// Optional feature, macro APPROX_MULT_ERR_STAT_EN:
//   out_err    out  exact product minus delivered product, aligned with out_p
//   err_cnt    out  32-bit saturating count of delivered results with a
//                   nonzero out_err; cleared by reset
// ---------------------------------------------------------------------------
module approx_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 out_approx
`ifdef APPROX_MULT_ERR_STAT_EN
  ,
  output logic [2*WIDTH-1:0]   out_err,
  output logic [31:0]          err_cnt
`endif
);

  localparam int PW = 2 * WIDTH;

  // Bit c is set for every column that OR-compression covers in approximate mode.
  function automatic logic [PW-1:0] low_mask_f();
    logic [PW-1:0] m;
    m = '0;
    for (int c = 0; c < PW; c++) begin
      m[c] = (c < APPROX_COLS) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  // 3:2 carry-save step. The result is {carry row (already shifted), sum row}.
  // The carry out of the top column falls off, so the final result wraps
  // modulo 2^PW.
  function automatic logic [2*PW-1:0] csa_f(input logic [PW-1:0] x,
                                            input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
    logic [PW-1:0] s;
    logic [PW-1:0] m;
    s = x ^ y ^ z;
    m = (x & y) | (x & z) | (y & z);
    return {m[PW-2:0], 1'b0, s};
  endfunction

  localparam logic [PW-1:0] LOW_MASK = low_mask_f();

  // Handshake
  logic en_s;

  // Stage 1 registers
  logic               s1_valid_r;
  logic [WIDTH-1:0]   s1_a_r;
  logic [WIDTH-1:0]   s1_b_r;
  logic               s1_approx_r;

  // Stage 2 combinational reduction and registers
  logic [PW-1:0]      pp_s;
  logic [PW-1:0]      or_cols_s;
  logic [PW-1:0]      red_sum_s;
  logic [PW-1:0]      red_carry_s;
  logic [2*PW-1:0]    red_csa_s;
  logic               s2_valid_r;
  logic [PW-1:0]      s2_sum_r;
  logic [PW-1:0]      s2_carry_r;
  logic               s2_approx_r;

  // Stage 3 output registers
  logic               out_valid_r;
  logic [PW-1:0]      out_p_r;
  logic               out_approx_r;

`ifdef APPROX_MULT_ERR_STAT_EN
  logic [PW-1:0]      ex_pp_s;
  logic [PW-1:0]      ex_sum_s;
  logic [PW-1:0]      ex_carry_s;
  logic [2*PW-1:0]    ex_csa_s;
  logic [PW-1:0]      s2_ex_sum_r;
  logic [PW-1:0]      s2_ex_carry_r;
  logic [PW-1:0]      s3_final_s;
  logic [PW-1:0]      s3_exact_s;
  logic [PW-1:0]      out_err_r;
  logic [31:0]        err_cnt_r;
`endif

  assign en_s       = !out_valid_r | out_ready;
  assign in_ready   = !rst_n | en_s;
  assign out_valid  = out_valid_r;
  assign out_p      = out_p_r;
  assign out_approx = out_approx_r;

  // Stage 1: capture operands and mode on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_a_r      <= '0;
      s1_b_r      <= '0;
      s1_approx_r <= 1'b0;
    end else if (en_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r      <= in_a;
        s1_b_r      <= in_b;
        s1_approx_r <= in_approx;
      end
    end
  end

  // Stage 2 logic: carry-save reduce the partial-product rows to a sum/carry pair.
  // In approximate mode the low columns are removed from the rows before
  // reduction, so no carry can originate there. Their OR is then merged into
  // the sum row. The low bits of the sum row are zero at that point, because
  // carries from the high columns only move left.
  always_comb begin
    pp_s        = '0;
    or_cols_s   = '0;
    red_sum_s   = '0;
    red_carry_s = '0;
    red_csa_s   = '0;
    for (int j = 0; j < WIDTH; j++) begin
      pp_s        = {{WIDTH{1'b0}}, s1_a_r & {WIDTH{s1_b_r[j]}}} << j;
      or_cols_s   = or_cols_s | (pp_s & LOW_MASK);
      pp_s        = s1_approx_r ? (pp_s & ~LOW_MASK) : pp_s;
      red_csa_s   = csa_f(red_sum_s, red_carry_s, pp_s);
      red_sum_s   = red_csa_s[PW-1:0];
      red_carry_s = red_csa_s[2*PW-1:PW];
    end
    red_sum_s = s1_approx_r ? (red_sum_s | or_cols_s) : red_sum_s;
  end

`ifdef APPROX_MULT_ERR_STAT_EN
  // Stage 2 shadow logic: always-exact reduction used to measure the approximation error.
  always_comb begin
    ex_pp_s    = '0;
    ex_sum_s   = '0;
    ex_carry_s = '0;
    ex_csa_s   = '0;
    for (int j = 0; j < WIDTH; j++) begin
      ex_pp_s    = {{WIDTH{1'b0}}, s1_a_r & {WIDTH{s1_b_r[j]}}} << j;
      ex_csa_s   = csa_f(ex_sum_s, ex_carry_s, ex_pp_s);
      ex_sum_s   = ex_csa_s[PW-1:0];
      ex_carry_s = ex_csa_s[2*PW-1:PW];
    end
  end
`endif

  // Stage 2 register: hold the reduced row pair and mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r  <= 1'b0;
      s2_sum_r    <= '0;
      s2_carry_r  <= '0;
      s2_approx_r <= 1'b0;
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_sum_r    <= red_sum_s;
        s2_carry_r  <= red_carry_s;
        s2_approx_r <= s1_approx_r;
      end
    end
  end

`ifdef APPROX_MULT_ERR_STAT_EN
  // Stage 2 shadow register: exact row pair travelling alongside the main pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_ex_sum_r   <= '0;
      s2_ex_carry_r <= '0;
    end else if (en_s && s1_valid_r) begin
      s2_ex_sum_r   <= ex_sum_s;
      s2_ex_carry_r <= ex_carry_s;
    end
  end

  assign s3_final_s = s2_sum_r + s2_carry_r;
  assign s3_exact_s = s2_ex_sum_r + s2_ex_carry_r;
`endif

  // Stage 3: final carry-propagate add into the output register.
  // The register holds its value while the result is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_p_r      <= '0;
      out_approx_r <= 1'b0;
    end else if (en_s) begin
      out_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        out_p_r      <= s2_sum_r + s2_carry_r;
        out_approx_r <= s2_approx_r;
      end
    end
  end

`ifdef APPROX_MULT_ERR_STAT_EN
  // Stage 3 error register: exact minus delivered product, aligned with out_p.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_err_r <= '0;
    end else if (en_s && s2_valid_r) begin
      out_err_r <= s3_exact_s - s3_final_s;
    end
  end

  // Saturating count of delivered results that carried a nonzero error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_r <= 32'd0;
    end else if (out_valid_r && out_ready && (out_err_r != '0) &&
                 (err_cnt_r != 32'hFFFF_FFFF)) begin
      err_cnt_r <= err_cnt_r + 32'd1;
    end
  end

  assign out_err = out_err_r;
  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Testbench for approx_mult_pipe. The expected results come from a
// column-by-column model of the multiplier arithmetic.
module tb_approx_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Instance under test with the default configuration (WIDTH=8, APPROX_COLS=8)
  logic        in_valid = 1'b0, in_ready, in_approx = 1'b0;
  logic [7:0]  in_a = 8'd0, in_b = 8'd0;
  logic        out_valid, out_ready = 1'b0, out_approx;
  logic [15:0] out_p;

  // Always-exact instance (APPROX_COLS=0)
  logic        in_valid1 = 1'b0, in_ready1, in_approx1 = 1'b1;
  logic [7:0]  in_a1 = 8'd0, in_b1 = 8'd0;
  logic        out_valid1, out_ready1 = 1'b1, out_approx1;
  logic [15:0] out_p1;

`ifdef APPROX_MULT_ERR_STAT_EN
  logic [15:0] out_err, out_err1;
  logic [31:0] err_cnt, err_cnt1;
`endif

  int checks_total = 0;
  int checks_pass  = 0;

  typedef struct {
    logic [15:0] p;
    logic        ap;
    logic [15:0] err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] q1[$];

  always #5 clk = ~clk;

  approx_mult_pipe #(.WIDTH(8), .APPROX_COLS(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_approx(out_approx)
`ifdef APPROX_MULT_ERR_STAT_EN
    , .out_err(out_err), .err_cnt(err_cnt)
`endif
  );

  approx_mult_pipe #(.WIDTH(8), .APPROX_COLS(0)) u_exact (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_approx(in_approx1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_p(out_p1), .out_approx(out_approx1)
`ifdef APPROX_MULT_ERR_STAT_EN
    , .out_err(out_err1), .err_cnt(err_cnt1)
`endif
  );

  // Column model: in approximate mode, each low column contributes OR(bits)
  // at its weight with no carry. Every other column contributes
  // popcount * weight.
  function automatic logic [15:0] model_p(input logic [7:0] a, input logic [7:0] b,
                                          input logic ap, input int ac);
    int unsigned hi;
    logic [15:0] lo;
    hi = 0;
    lo = 16'd0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[i] && b[j]) begin
          if (ap && (i + j) < ac) lo[i+j] = 1'b1;
          else hi += (32'd1 << (i + j));
        end
    return 16'(hi) + lo;
  endfunction

  // One clock cycle on the main instance. The task drives the inputs,
  // samples the outputs away from the edge, and records an accepted
  // transaction in the scoreboard.
  task automatic cycle0(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic ap, input logic ordy,
                        output logic fired, output logic [15:0] p, output logic pap,
                        output logic rdy, output logic [15:0] perr);
    exp_t e;
    in_valid = v; in_a = a; in_b = b; in_approx = ap; out_ready = ordy;
    #1;
    rdy   = in_ready;
    fired = out_valid && out_ready;
    p     = out_p;
    pap   = out_approx;
`ifdef APPROX_MULT_ERR_STAT_EN
    perr  = out_err;
`else
    perr  = 16'd0;
`endif
    if (v && in_ready && rst_n) begin
      e.p   = model_p(a, b, ap, 8);
      e.ap  = ap;
      e.err = 16'(a * b) - e.p;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready_early: got %b expected 1", in_ready);
    else checks_pass++;
    repeat (2) @(posedge clk);
    #1;
    checks_total++;
    if (out_valid !== 1'b0 || out_p !== 16'd0 || out_approx !== 1'b0 || in_ready !== 1'b1 ||
        out_valid1 !== 1'b0)
      $display("FAIL reset_state: got valid=%b p=%0d ap=%b rdy=%b valid1=%b expected 0 0 0 1 0",
               out_valid, out_p, out_approx, in_ready, out_valid1);
    else checks_pass++;
`ifdef APPROX_MULT_ERR_STAT_EN
    checks_total++;
    if (err_cnt !== 32'd0 || out_err !== 16'd0)
      $display("FAIL reset_err: got cnt=%0d err=%0d expected 0 0", err_cnt, out_err);
    else checks_pass++;
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [7:0]  da[4] = '{8'd255, 8'd255, 8'd3, 8'd3};
    logic [7:0]  db[4] = '{8'd255, 8'd255, 8'd3, 8'd5};
    logic        dap[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] dp[4] = '{16'd63487, 16'd65025, 16'd7, 16'd15};
    logic [15:0] derr[4] = '{16'd1538, 16'd0, 16'd2, 16'd0};
    logic f, pap, rdy;
    logic [15:0] p, perr, gp, gerr;
    logic gap;
    int lat;
    for (int v = 0; v < 4; v++) begin
      cycle0(1'b1, da[v], db[v], dap[v], 1'b1, f, p, pap, rdy, perr);
      lat = -1; gp = 16'd0; gap = 1'b0; gerr = 16'd0;
      for (int k = 1; k <= 6; k++) begin
        cycle0(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, f, p, pap, rdy, perr);
        if (f && lat < 0) begin
          lat = k; gp = p; gap = pap; gerr = perr;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      checks_total++;
      if (lat != 3) $display("FAIL directed_latency[%0d]: got %0d expected 3", v, lat);
      else checks_pass++;
      checks_total++;
      if (gp !== dp[v] || gap !== dap[v])
        $display("FAIL directed_p[%0d]: got p=%0d ap=%b expected p=%0d ap=%b", v, gp, gap, dp[v], dap[v]);
      else checks_pass++;
`ifdef APPROX_MULT_ERR_STAT_EN
      checks_total++;
      if (gerr !== derr[v]) $display("FAIL directed_err[%0d]: got %0d expected %0d", v, gerr, derr[v]);
      else checks_pass++;
      if (v == 0) begin
        checks_total++;
        if (err_cnt !== 32'd1) $display("FAIL directed_err_cnt: got %0d expected 1", err_cnt);
        else checks_pass++;
      end
`else
      if (derr[v] > 16'd0 && gerr !== 16'd0)
        $display("FAIL directed_err_tb[%0d]: got %0d expected 0", v, gerr);
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic f, pap, rdy;
    logic [15:0] p, perr;
    int first, last, n;
    exp_t e;
    first = -1; last = -1; n = 0;
    for (int k = 0; k < 16; k++) begin
      cycle0(k < 10, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, f, p, pap, rdy, perr);
      if (f) begin
        if (first < 0) first = k;
        last = k; n++;
        checks_total++;
        if (exp_q.size() == 0) $display("FAIL b2b_unexpected: got output p=%0d expected none", p);
        else begin
          e = exp_q.pop_front();
          if (p !== e.p || pap !== e.ap
`ifdef APPROX_MULT_ERR_STAT_EN
              || perr !== e.err
`endif
             ) $display("FAIL b2b_result: got p=%0d ap=%b err=%0d expected p=%0d ap=%b err=%0d",
                        p, pap, perr, e.p, e.ap, e.err);
          else checks_pass++;
        end
      end
    end
    checks_total++;
    if (first != 3 || last != 12 || n != 10)
      $display("FAIL b2b_throughput: got first=%0d last=%0d n=%0d expected 3 12 10", first, last, n);
    else checks_pass++;
  endtask

  task automatic test_stall();
    logic f, pap, rdy;
    logic [15:0] p, perr, held;
    int n;
    exp_t e;
    for (int k = 0; k < 3; k++)
      cycle0(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, f, p, pap, rdy, perr);
    held = out_p;
    for (int k = 0; k < 5; k++) begin
      cycle0(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, f, p, pap, rdy, perr);
      checks_total++;
      if (rdy !== 1'b0 || out_valid !== 1'b1 || p !== held)
        $display("FAIL stall_hold[%0d]: got rdy=%b valid=%b p=%0d expected 0 1 %0d",
                 k, rdy, out_valid, p, held);
      else checks_pass++;
    end
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle0(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, f, p, pap, rdy, perr);
      if (f) begin
        n++;
        checks_total++;
        if (exp_q.size() == 0) $display("FAIL stall_unexpected: got output p=%0d expected none", p);
        else begin
          e = exp_q.pop_front();
          if (p !== e.p || pap !== e.ap)
            $display("FAIL stall_drain: got p=%0d ap=%b expected p=%0d ap=%b", p, pap, e.p, e.ap);
          else checks_pass++;
        end
      end
    end
    checks_total++;
    if (n != 3 || exp_q.size() != 0)
      $display("FAIL stall_count: got drained=%0d left=%0d expected 3 0", n, exp_q.size());
    else checks_pass++;
  endtask

  task automatic test_random_handshake();
    logic f, pap, rdy;
    logic [15:0] p, perr;
    exp_t e;
    for (int k = 0; k < 320; k++) begin
      cycle0((k < 300) && ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 1'($urandom),
             (k >= 300) || ($urandom_range(0, 9) < 6), f, p, pap, rdy, perr);
      if (f) begin
        checks_total++;
        if (exp_q.size() == 0) $display("FAIL rand_unexpected: got output p=%0d expected none", p);
        else begin
          e = exp_q.pop_front();
          if (p !== e.p || pap !== e.ap
`ifdef APPROX_MULT_ERR_STAT_EN
              || perr !== e.err
`endif
             ) $display("FAIL rand_result: got p=%0d ap=%b err=%0d expected p=%0d ap=%b err=%0d",
                        p, pap, perr, e.p, e.ap, e.err);
          else checks_pass++;
        end
      end
    end
    checks_total++;
    if (exp_q.size() != 0) $display("FAIL rand_leftover: got %0d pending expected 0", exp_q.size());
    else checks_pass++;
  endtask

  task automatic test_reset_mid();
    logic f, pap, rdy;
    logic [15:0] p, perr;
    int stale;
    for (int k = 0; k < 3; k++)
      cycle0(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b1, f, p, pap, rdy, perr);
    rst_n = 1'b0;
    cycle0(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, f, p, pap, rdy, perr);
    rst_n = 1'b1;
    exp_q.delete();
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_mid_valid: got %b expected 0", out_valid);
    else checks_pass++;
`ifdef APPROX_MULT_ERR_STAT_EN
    checks_total++;
    if (err_cnt !== 32'd0) $display("FAIL reset_mid_err_cnt: got %0d expected 0", err_cnt);
    else checks_pass++;
`endif
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      cycle0(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, f, p, pap, rdy, perr);
      if (f) stale++;
    end
    checks_total++;
    if (stale != 0) $display("FAIL reset_mid_stale: got %0d outputs expected 0", stale);
    else checks_pass++;
  endtask

  task automatic test_exact_cols0();
    logic [7:0] a, b;
    logic [15:0] e;
    int errs;
    errs = 0;
    for (int k = 0; k < 1006; k++) begin
      a = 8'($urandom); b = 8'($urandom);
      in_valid1 = (k < 1000); in_a1 = a; in_b1 = b; in_approx1 = 1'b1; out_ready1 = 1'b1;
      #1;
      if (in_valid1 && in_ready1) q1.push_back(16'(a) * 16'(b));
      if (out_valid1) begin
        checks_total++;
        if (q1.size() == 0) $display("FAIL cols0_unexpected: got p=%0d expected none", out_p1);
        else begin
          e = q1.pop_front();
          if (out_p1 !== e) begin
            errs++;
            if (errs < 10) $display("FAIL cols0_product: got %0d expected %0d", out_p1, e);
          end else checks_pass++;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid1 = 1'b0;
    checks_total++;
    if (q1.size() != 0) $display("FAIL cols0_leftover: got %0d pending expected 0", q1.size());
    else checks_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random_handshake();
    test_reset_mid();
    test_exact_cols0();
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, pipelined successor to the 8x8 approximate compressor multiplier. Supports WIDTH x WIDTH unsigned operands.
- Approximation is selectable per transaction and confined to the low APPROX_COLS columns.
- 3-stage pipeline with valid/ready handshakes on both sides. Sits between operand source and downstream accumulator/filter datapath.

Parameters:
WIDTH, 8, operand width; even, 4..16.
APPROX_COLS, 8, columns 0..APPROX_COLS-1 use approximate OR-compression; 0..2*WIDTH-1; 0 gives an always-exact multiplier.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset
in_valid  in  1  operand transfer request
in_ready  out  1  block accepts operands this cycle
in_a  in  WIDTH  multiplicand, unsigned
in_b  in  WIDTH  multiplier, unsigned
in_approx  in  1  1 = approximate mode, 0 = exact mode, per transaction
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_p  out  2*WIDTH  product
out_approx  out  1  mode the result was computed in

Behaviour:
- Clocking and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values: all stage valid flags 0. out_valid=0, out_p=0, out_approx=0.
- in_ready is combinational and is 1 while rst_n is low.
- Arithmetic model. Column c holds partial-product bits a[i]&b[j] with i+j=c.
  - Exact: P = sum over all c of popcount(col c)*2^c.
  - Approx: P = sum over c>=APPROX_COLS of popcount(col c)*2^c, plus sum over c<APPROX_COLS of OR(col c)*2^c.
  - Low columns produce no carry. Result truncated to 2*WIDTH bits (never overflows). Approx P <= exact P.
- Stages:
  - S1 registers operands and mode.
  - S2 builds partial products and reduces them to two rows (sum, carry). Low columns use the OR/AND 4:2 compressor form. High columns use exact FA/HA/4:2 trees.
  - S3 adds the final carry-propagate and holds the output register.
- Latency: exactly 3 cycles from an accepted input (in_valid & in_ready) to out_valid, with no stall. Throughput is 1 per cycle.
- Stall rule: global enable en = !out_valid | out_ready, and in_ready = en.
  - When en=0, every stage holds.
  - out_p and out_approx stay stable while out_valid & !out_ready.
- Bubbles: in_valid=0 while en=1 inserts a bubble; stage valid bits propagate 0.
- Simultaneous events: an accept and a drain in the same cycle are both taken; no loss and no duplication. Ordering is strictly FIFO.
- in_a, in_b and in_approx are sampled only on accept. Changing them while in_ready=0 has no effect.
- Reset mid-operation: all in-flight transactions are discarded. out_valid=0 on the cycle after rst_n is sampled low.
- No state other than the pipeline registers (plus the counter below when that feature is enabled).

Optional Feature:
- Macro APPROX_MULT_ERR_STAT_EN.
- Defined:
  - Adds an exact product path alongside the main path.
  - Adds output out_err (2*WIDTH), equal to exact P minus delivered P, aligned with out_p. out_err=0 for exact-mode results.
  - Adds output err_cnt (32 bits), incremented on each output handshake where out_err != 0. It saturates at 2^32-1 and is cleared by reset.
- Undefined: these ports and logic are absent. Port list, latency and out_p are identical.

Test Plan:
- WIDTH=8, APPROX_COLS=8, a=255, b=255, approx=1 -> out_p=63487 three cycles after accept. With the feature: out_err=1538, err_cnt=1.
- Same operands, approx=0 -> out_p=65025, out_err=0. Then a=3, b=3, approx=1 -> out_p=7, out_err=2. a=3, b=5, approx=1 -> out_p=15, out_err=0.
- Stream 10 back-to-back random transactions with out_ready=1 -> one result per cycle, in order, each matching the model.
- Hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, out_p stable, no result lost. Release -> remaining results drain in order.
- Assert rst_n=0 for one cycle with 3 transactions in flight -> out_valid=0 the next cycle, no stale results emitted, err_cnt=0.
- APPROX_COLS=0, 1000 random pairs with approx=1 -> out_p equals a*b for every pair.
